// File: rtl/decode_stage_if.sv
// Bundles the IF/ID handshake, register-file read/bypass paths and ID/EX outputs of decode_stage.
// slave is the decode stage's view; master is the surrounding pipeline's view.
interface decode_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  if_valid_i;
    logic [31:0]           if_instr_i;
    logic [XLEN-1:0]       if_pc_i;
    logic                  id_ready_o;
    logic [REG_ADDR_W-1:0] rs1_addr_o;
    logic [REG_ADDR_W-1:0] rs2_addr_o;
    logic [XLEN-1:0]       rs1_data_i;
    logic [XLEN-1:0]       rs2_data_i;
    logic [REG_ADDR_W-1:0] wb_rd_addr_i;
    logic [XLEN-1:0]       wb_rd_data_i;
    logic                  wb_reg_write_en_i;
    logic                  flush_i;
    logic                  ex_ready_i;
    logic                  ex_valid_o;
    logic [XLEN-1:0]       ex_pc_o;
    logic [XLEN-1:0]       ex_rs1_val_o;
    logic [XLEN-1:0]       ex_rs2_val_o;
    logic [XLEN-1:0]       ex_imm_o;
    logic [REG_ADDR_W-1:0] ex_rd_addr_o;
    logic [REG_ADDR_W-1:0] ex_rs1_addr_o;
    logic [REG_ADDR_W-1:0] ex_rs2_addr_o;
    logic [3:0]            ex_alu_op_o;
    logic                  ex_alu_src_imm_o;
    logic                  ex_mem_read_o;
    logic                  ex_mem_write_o;
    logic                  ex_reg_write_o;
    logic                  ex_branch_o;
    logic                  ex_jump_o;
    logic [2:0]            ex_funct3_o;
    logic                  ex_illegal_o;

    modport slave (
        input  if_valid_i, if_instr_i, if_pc_i, rs1_data_i, rs2_data_i,
               wb_rd_addr_i, wb_rd_data_i, wb_reg_write_en_i, flush_i, ex_ready_i,
        output id_ready_o, rs1_addr_o, rs2_addr_o, ex_valid_o, ex_pc_o,
               ex_rs1_val_o, ex_rs2_val_o, ex_imm_o, ex_rd_addr_o, ex_rs1_addr_o,
               ex_rs2_addr_o, ex_alu_op_o, ex_alu_src_imm_o, ex_mem_read_o,
               ex_mem_write_o, ex_reg_write_o, ex_branch_o, ex_jump_o, ex_funct3_o,
               ex_illegal_o
    );

    modport master (
        output if_valid_i, if_instr_i, if_pc_i, rs1_data_i, rs2_data_i,
               wb_rd_addr_i, wb_rd_data_i, wb_reg_write_en_i, flush_i, ex_ready_i,
        input  id_ready_o, rs1_addr_o, rs2_addr_o, ex_valid_o, ex_pc_o,
               ex_rs1_val_o, ex_rs2_val_o, ex_imm_o, ex_rd_addr_o, ex_rs1_addr_o,
               ex_rs2_addr_o, ex_alu_op_o, ex_alu_src_imm_o, ex_mem_read_o,
               ex_mem_write_o, ex_reg_write_o, ex_branch_o, ex_jump_o, ex_funct3_o,
               ex_illegal_o
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode: immediates, control, write-back bypass and load-use bubble into the ID/EX register.
// Latency: one cycle from acceptance to ex_valid_o; one extra bubble on a load-use dependence.
// Backpressure: holds ID/EX while EX stalls; DECODE_ILLEGAL_CHECK_EN adds illegal-instruction flagging.
module decode_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_val;
        logic [XLEN-1:0]       rs2_val;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [3:0]            alu_op;
        logic                  alu_src_imm;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic                  branch;
        logic                  jump;
        logic [2:0]            funct3;
        logic                  illegal;
    } idex_t;

    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt, input logic allow_sub);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [31:0]           instr;
    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [XLEN-1:0]       imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0]       rs1_val, rs2_val;
    logic                  uses_rs1, uses_rs2, hazard, known_op;
    idex_t                 dec;
    idex_t                 ex_q, ex_d;
    logic                  ex_valid_q, ex_valid_d;

    assign instr  = bus.if_instr_i;
    assign opcode = instr[6:0];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign bus.rs1_addr_o = rs1;
    assign bus.rs2_addr_o = rs2;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // The register file writes on the clock edge, so a same-cycle write-back must be forwarded here.
    assign rs1_val = (rs1 == '0) ? '0 :
                     (bus.wb_reg_write_en_i && bus.wb_rd_addr_i == rs1) ? bus.wb_rd_data_i : bus.rs1_data_i;
    assign rs2_val = (rs2 == '0) ? '0 :
                     (bus.wb_reg_write_en_i && bus.wb_rd_addr_i == rs2) ? bus.wb_rd_data_i : bus.rs2_data_i;

    assign uses_rs1 = (opcode == OPC_JALR) || (opcode == OPC_BRANCH) || (opcode == OPC_LOAD) ||
                      (opcode == OPC_STORE) || (opcode == OPC_OPIMM) || (opcode == OPC_OP);
    assign uses_rs2 = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);

    assign hazard = ex_valid_q && ex_q.mem_read && (ex_q.rd_addr != '0) &&
                    ((uses_rs1 && ex_q.rd_addr == rs1) || (uses_rs2 && ex_q.rd_addr == rs2));

    assign bus.id_ready_o = !rst && (bus.flush_i || ((!ex_valid_q || bus.ex_ready_i) && !hazard));

    always_comb begin
        dec          = '0;
        known_op     = 1'b1;
        dec.pc       = bus.if_pc_i;
        dec.rs1_val  = rs1_val;
        dec.rs2_val  = rs2_val;
        dec.rd_addr  = instr[11:7];
        dec.rs1_addr = rs1;
        dec.rs2_addr = rs2;
        dec.funct3   = instr[14:12];
        case (opcode)
            OPC_LUI:    begin dec.alu_op = ALU_PASSB; dec.imm = imm_u; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1; end
            OPC_AUIPC:  begin dec.alu_op = ALU_ADD;   dec.imm = imm_u; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1; end
            OPC_JAL:    begin dec.jump = 1'b1; dec.reg_write = 1'b1; dec.imm = imm_j; end
            OPC_JALR:   begin dec.jump = 1'b1; dec.reg_write = 1'b1; dec.imm = imm_i; dec.alu_src_imm = 1'b1; end
            OPC_BRANCH: begin dec.branch = 1'b1; dec.imm = imm_b; dec.alu_op = ALU_SUB; end
            OPC_LOAD:   begin dec.mem_read = 1'b1; dec.reg_write = 1'b1; dec.imm = imm_i; dec.alu_src_imm = 1'b1; end
            OPC_STORE:  begin dec.mem_write = 1'b1; dec.imm = imm_s; dec.alu_src_imm = 1'b1; end
            OPC_OPIMM:  begin
                dec.alu_op      = alu_sel(instr[14:12], instr[30], 1'b0);
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OPC_OP:     begin
                dec.alu_op    = alu_sel(instr[14:12], instr[30], 1'b1);
                dec.reg_write = 1'b1;
            end
            default:    known_op = 1'b0;
        endcase
`ifdef DECODE_ILLEGAL_CHECK_EN
        if (!known_op || instr[1:0] != 2'b11 ||
            (opcode == OPC_OP && instr[31:25] != 7'h00 && instr[31:25] != 7'h20)) begin
            dec.illegal   = 1'b1;
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
        end
`else
        dec.illegal = 1'b0;
`endif
        if (dec.rd_addr == '0) begin
            dec.reg_write = 1'b0;
        end
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        if (bus.flush_i) begin
            ex_valid_d = 1'b0;
            ex_d       = '0;
        end else if (!ex_valid_q || bus.ex_ready_i) begin
            if (hazard || !bus.if_valid_i) begin
                ex_valid_d = 1'b0;
                ex_d       = '0;
            end else begin
                ex_valid_d = 1'b1;
                ex_d       = dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
        end
    end

    assign bus.ex_valid_o       = ex_valid_q;
    assign bus.ex_pc_o          = ex_q.pc;
    assign bus.ex_rs1_val_o     = ex_q.rs1_val;
    assign bus.ex_rs2_val_o     = ex_q.rs2_val;
    assign bus.ex_imm_o         = ex_q.imm;
    assign bus.ex_rd_addr_o     = ex_q.rd_addr;
    assign bus.ex_rs1_addr_o    = ex_q.rs1_addr;
    assign bus.ex_rs2_addr_o    = ex_q.rs2_addr;
    assign bus.ex_alu_op_o      = ex_q.alu_op;
    assign bus.ex_alu_src_imm_o = ex_q.alu_src_imm;
    assign bus.ex_mem_read_o    = ex_q.mem_read;
    assign bus.ex_mem_write_o   = ex_q.mem_write;
    assign bus.ex_reg_write_o   = ex_q.reg_write;
    assign bus.ex_branch_o      = ex_q.branch;
    assign bus.ex_jump_o        = ex_q.jump;
    assign bus.ex_funct3_o      = ex_q.funct3;
    assign bus.ex_illegal_o     = ex_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with hand-computed expectations.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst;
    logic [31:0] rf [32];
    int vectors = 0;
    int errors  = 0;

    decode_stage_if bus ();
    decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.rs1_data_i = rf[bus.rs1_addr_o];
    assign bus.rs2_data_i = rf[bus.rs2_addr_o];

    // sw x2,8(x1); beq x0,x0,-4; jal x1,8; lui x10,0x12345; auipc x11,1; jalr x0,0(x1)
    localparam logic [31:0] T_INSTR [6] = '{32'h0020A423, 32'hFE000EE3, 32'h008000EF,
                                            32'h12345537, 32'h00001597, 32'h00008067};
    localparam logic [31:0] T_IMM   [6] = '{32'h8, 32'hFFFFFFFC, 32'h8, 32'h12345000, 32'h1000, 32'h0};
    localparam logic [3:0]  T_ALU   [6] = '{4'd0, 4'd1, 4'd0, 4'd10, 4'd0, 4'd0};
    // {alu_src_imm, mem_read, mem_write, reg_write, branch, jump}
    localparam logic [5:0]  T_CTRL  [6] = '{6'b101000, 6'b000010, 6'b000101,
                                            6'b100100, 6'b100100, 6'b100001};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        bus.if_valid_i = 1'b1;
        bus.if_instr_i = instr;
        bus.if_pc_i    = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'h00500093, 32'h100);
        bus.ex_ready_i = 1'b1;
        step();
        step();
        vectors++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", bus.ex_valid_o); end
        vectors++; if (bus.ex_imm_o !== 32'h0) begin errors++; $display("FAIL rst_imm got %h want 0", bus.ex_imm_o); end
        vectors++; if (bus.ex_reg_write_o !== 1'b0) begin errors++; $display("FAIL rst_regwr got %0h want 0", bus.ex_reg_write_o); end
        vectors++; if (bus.id_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %0h want 0", bus.id_ready_o); end
        rst = 1'b0;
        bus.if_valid_i = 1'b0;
        #1;
        vectors++; if (bus.id_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %0h want 1", bus.id_ready_o); end
    endtask

    task automatic test_addi();
        drive(32'h00500093, 32'h100);
        step();
        vectors++; if (bus.ex_valid_o !== 1'b1) begin errors++; $display("FAIL addi_valid got %0h want 1", bus.ex_valid_o); end
        vectors++; if (bus.ex_imm_o !== 32'd5) begin errors++; $display("FAIL addi_imm got %h want 5", bus.ex_imm_o); end
        vectors++; if (bus.ex_rd_addr_o !== 5'd1) begin errors++; $display("FAIL addi_rd got %0d want 1", bus.ex_rd_addr_o); end
        vectors++; if (bus.ex_alu_op_o !== 4'd0) begin errors++; $display("FAIL addi_alu got %0d want 0", bus.ex_alu_op_o); end
        vectors++; if (bus.ex_alu_src_imm_o !== 1'b1) begin errors++; $display("FAIL addi_srcimm got %0h want 1", bus.ex_alu_src_imm_o); end
        vectors++; if (bus.ex_reg_write_o !== 1'b1) begin errors++; $display("FAIL addi_regwr got %0h want 1", bus.ex_reg_write_o); end
        vectors++; if (bus.ex_rs1_val_o !== 32'h0) begin errors++; $display("FAIL addi_rs1 got %h want 0", bus.ex_rs1_val_o); end
        vectors++; if (bus.ex_pc_o !== 32'h100) begin errors++; $display("FAIL addi_pc got %h want 100", bus.ex_pc_o); end
    endtask

    task automatic test_bypass();
        rf[2] = 32'h0;
        bus.wb_reg_write_en_i = 1'b1;
        bus.wb_rd_addr_i      = 5'd2;
        bus.wb_rd_data_i      = 32'hDEADBEEF;
        drive(32'h002101B3, 32'h104);
        step();
        vectors++; if (bus.ex_rs1_val_o !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_rs1 got %h want deadbeef", bus.ex_rs1_val_o); end
        vectors++; if (bus.ex_rs2_val_o !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_rs2 got %h want deadbeef", bus.ex_rs2_val_o); end
        vectors++; if (bus.ex_rd_addr_o !== 5'd3) begin errors++; $display("FAIL byp_rd got %0d want 3", bus.ex_rd_addr_o); end
        vectors++; if (bus.ex_alu_src_imm_o !== 1'b0) begin errors++; $display("FAIL byp_srcimm got %0h want 0", bus.ex_alu_src_imm_o); end
        rf[2] = 32'h11;
        bus.wb_rd_addr_i = 5'd7;
        bus.wb_rd_data_i = 32'h5555;
        drive(32'h002101B3, 32'h108);
        step();
        vectors++; if (bus.ex_rs1_val_o !== 32'h11) begin errors++; $display("FAIL nobyp_rs1 got %h want 11", bus.ex_rs1_val_o); end
        bus.wb_reg_write_en_i = 1'b0;
    endtask

    task automatic test_load_use();
        drive(32'h0000A283, 32'h200);
        step();
        vectors++; if (bus.ex_mem_read_o !== 1'b1) begin errors++; $display("FAIL lw_memrd got %0h want 1", bus.ex_mem_read_o); end
        vectors++; if (bus.ex_funct3_o !== 3'd2) begin errors++; $display("FAIL lw_f3 got %0d want 2", bus.ex_funct3_o); end
        drive(32'h00528333, 32'h204);
        #1;
        vectors++; if (bus.id_ready_o !== 1'b0) begin errors++; $display("FAIL lu_ready got %0h want 0", bus.id_ready_o); end
        step();
        vectors++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL lu_bubble got %0h want 0", bus.ex_valid_o); end
        vectors++; if (bus.id_ready_o !== 1'b1) begin errors++; $display("FAIL lu_ready2 got %0h want 1", bus.id_ready_o); end
        step();
        vectors++; if (bus.ex_valid_o !== 1'b1) begin errors++; $display("FAIL lu_add_valid got %0h want 1", bus.ex_valid_o); end
        vectors++; if (bus.ex_rd_addr_o !== 5'd6) begin errors++; $display("FAIL lu_add_rd got %0d want 6", bus.ex_rd_addr_o); end
        vectors++; if (bus.ex_pc_o !== 32'h204) begin errors++; $display("FAIL lu_add_pc got %h want 204", bus.ex_pc_o); end
    endtask

    task automatic test_stall();
        drive(32'hFFF08393, 32'h300);
        step();
        vectors++; if (bus.ex_imm_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL st_imm got %h want ffffffff", bus.ex_imm_o); end
        bus.ex_ready_i = 1'b0;
        drive(32'h00339413, 32'h304);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (bus.id_ready_o !== 1'b0) begin errors++; $display("FAIL st_ready%0d got %0h want 0", i, bus.id_ready_o); end
            step();
            vectors++; if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_addr_o !== 5'd7 || bus.ex_pc_o !== 32'h300 || bus.ex_imm_o !== 32'hFFFFFFFF)
                begin errors++; $display("FAIL st_hold%0d got v=%0h rd=%0d pc=%h want v=1 rd=7 pc=300", i, bus.ex_valid_o, bus.ex_rd_addr_o, bus.ex_pc_o); end
        end
        bus.ex_ready_i = 1'b1;
        #1;
        vectors++; if (bus.id_ready_o !== 1'b1) begin errors++; $display("FAIL st_release got %0h want 1", bus.id_ready_o); end
        step();
        vectors++; if (bus.ex_rd_addr_o !== 5'd8 || bus.ex_alu_op_o !== 4'd2 || bus.ex_imm_o !== 32'd3)
            begin errors++; $display("FAIL slli got rd=%0d alu=%0d imm=%h want rd=8 alu=2 imm=3", bus.ex_rd_addr_o, bus.ex_alu_op_o, bus.ex_imm_o); end
        drive(32'h40445493, 32'h308);
        step();
        vectors++; if (bus.ex_alu_op_o !== 4'd7 || bus.ex_imm_o !== 32'h404)
            begin errors++; $display("FAIL srai got alu=%0d imm=%h want alu=7 imm=404", bus.ex_alu_op_o, bus.ex_imm_o); end
    endtask

    task automatic test_flush();
        drive(32'h0000A283, 32'h400);
        step();
        drive(32'h00528333, 32'h404);
        bus.flush_i = 1'b1;
        #1;
        vectors++; if (bus.id_ready_o !== 1'b1) begin errors++; $display("FAIL fl_ready got %0h want 1", bus.id_ready_o); end
        step();
        vectors++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL fl_valid got %0h want 0", bus.ex_valid_o); end
        bus.flush_i = 1'b0;
        drive(32'h00100013, 32'h408);
        step();
        vectors++; if (bus.ex_valid_o !== 1'b1 || bus.ex_reg_write_o !== 1'b0)
            begin errors++; $display("FAIL x0_write got v=%0h rw=%0h want v=1 rw=0", bus.ex_valid_o, bus.ex_reg_write_o); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ctrl;
        for (int i = 0; i < 6; i++) begin
            drive(T_INSTR[i], 32'h500 + 32'(i * 4));
            step();
            ctrl = {bus.ex_alu_src_imm_o, bus.ex_mem_read_o, bus.ex_mem_write_o,
                    bus.ex_reg_write_o, bus.ex_branch_o, bus.ex_jump_o};
            vectors++;
            if (bus.ex_valid_o !== 1'b1 || bus.ex_imm_o !== T_IMM[i] || bus.ex_alu_op_o !== T_ALU[i] || ctrl !== T_CTRL[i])
                begin errors++; $display("FAIL b2b%0d got v=%0h imm=%h alu=%0d ctrl=%b want imm=%h alu=%0d ctrl=%b",
                    i, bus.ex_valid_o, bus.ex_imm_o, bus.ex_alu_op_o, ctrl, T_IMM[i], T_ALU[i], T_CTRL[i]); end
        end
    endtask

    task automatic test_illegal();
        logic exp_ill;
        logic [4:0] ctrl;
`ifdef DECODE_ILLEGAL_CHECK_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        drive(32'hFFFFFFFF, 32'h600);
        step();
        ctrl = {bus.ex_mem_read_o, bus.ex_mem_write_o, bus.ex_reg_write_o, bus.ex_branch_o, bus.ex_jump_o};
        vectors++; if (bus.ex_illegal_o !== exp_ill) begin errors++; $display("FAIL ill_flag got %0h want %0h", bus.ex_illegal_o, exp_ill); end
        vectors++; if (ctrl !== 5'b0 || bus.ex_valid_o !== 1'b1) begin errors++; $display("FAIL ill_ctrl got v=%0h ctrl=%b want v=1 ctrl=0", bus.ex_valid_o, ctrl); end
        bus.if_valid_i = 1'b0;
        step();
        vectors++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid got %0h want 0", bus.ex_valid_o); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rst                   = 1'b1;
        bus.if_valid_i        = 1'b0;
        bus.if_instr_i        = 32'h0;
        bus.if_pc_i           = 32'h0;
        bus.wb_rd_addr_i      = 5'd0;
        bus.wb_rd_data_i      = 32'h0;
        bus.wb_reg_write_en_i = 1'b0;
        bus.flush_i           = 1'b0;
        bus.ex_ready_i        = 1'b1;
        test_reset();
        test_addi();
        test_bypass();
        test_load_use();
        test_stall();
        test_flush();
        test_back_to_back();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
